operand_fetch_sequencer: RTL and testbench

- Sequences the operand-byte readers that follow opcode fetch: ModR/M reader, then displacement reader, then immediate reader.
- Shares the single prefetch-FIFO read port between those three readers; exactly one reader owns the port in any cycle.
- Counts the operand bytes popped so the IP-advance logic can use the count.
- Sits between the opcode decoder (which issues start and the decoded flags) and the three reader instances.

---
 rtl/operand_fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_operand_fetch_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_sequencer.sv
// Sequences the ModR/M, displacement and immediate readers after opcode fetch,
// arbitrates the shared prefetch-FIFO read port and counts operand bytes popped.
module operand_fetch_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       has_modrm,
  input  logic       need_imm,
  input  logic       imm_is_8bit,
  input  logic       flush,
  output logic       busy,
  output logic       complete,
  output logic [2:0] operand_bytes,
  output logic       modrm_start,
  input  logic       modrm_complete,
  input  logic [1:0] modrm_disp_bytes,
  input  logic       modrm_rd_en,
  output logic       disp_start,
  output logic       disp_is_8bit,
  input  logic       disp_complete,
  input  logic       disp_rd_en,
  output logic       imm_start,
  output logic       imm_is_8bit_out,
  input  logic       imm_complete,
  input  logic       imm_rd_en,
  output logic       fifo_rd_en
);

  typedef enum logic [1:0] {IDLE, MODRM, DISP, IMM} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_needImm;
  logic       r_immIs8bit;
  logic [1:0] r_dispLen;
  logic [2:0] r_opBytes;

  logic       w_active;
  logic       w_accept;
  logic       w_modrmDone;
  logic [1:0] w_dispLenIn;

  assign w_active    = ~reset & ~flush;
  assign w_accept    = w_active & start & (r_state == IDLE);
  assign w_modrmDone = (r_state == MODRM) & modrm_complete;
  // A decoded displacement length of 3 is not legal; treat it as a word.
  assign w_dispLenIn = (modrm_disp_bytes == 2'd3) ? 2'd2 : modrm_disp_bytes;

  always_comb begin
    w_nextState = r_state;
    modrm_start = 1'b0;
    disp_start  = 1'b0;
    imm_start   = 1'b0;
    complete    = 1'b0;
    if (flush) begin
      w_nextState = IDLE;
    end else if (!reset) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (has_modrm) begin
              modrm_start = 1'b1;
              w_nextState = MODRM;
            end else if (need_imm) begin
              imm_start   = 1'b1;
              w_nextState = IMM;
            end else begin
              complete = 1'b1;
            end
          end
        end
        MODRM: begin
          if (modrm_complete) begin
            if (w_dispLenIn != 2'd0) begin
              disp_start  = 1'b1;
              w_nextState = DISP;
            end else if (r_needImm) begin
              imm_start   = 1'b1;
              w_nextState = IMM;
            end else begin
              complete    = 1'b1;
              w_nextState = IDLE;
            end
          end
        end
        DISP: begin
          if (disp_complete) begin
            if (r_needImm) begin
              imm_start   = 1'b1;
              w_nextState = IMM;
            end else begin
              complete    = 1'b1;
              w_nextState = IDLE;
            end
          end
        end
        IMM: begin
          if (imm_complete) begin
            complete    = 1'b1;
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // The reader being started this cycle owns the port ahead of the state's reader.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (w_active) begin
      if (modrm_start)      fifo_rd_en = modrm_rd_en;
      else if (disp_start)  fifo_rd_en = disp_rd_en;
      else if (imm_start)   fifo_rd_en = imm_rd_en;
      else begin
        case (r_state)
          MODRM:   fifo_rd_en = modrm_rd_en;
          DISP:    fifo_rd_en = disp_rd_en;
          IMM:     fifo_rd_en = imm_rd_en;
          default: fifo_rd_en = 1'b0;
        endcase
      end
    end
  end

  assign busy            = ~reset & (w_accept | (r_state != IDLE)) & ~complete;
  assign disp_is_8bit    = w_modrmDone ? (w_dispLenIn == 2'd1) : (r_dispLen == 2'd1);
  assign imm_is_8bit_out = ((r_state == IDLE) & start) ? imm_is_8bit : r_immIs8bit;
  assign operand_bytes   = r_opBytes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_needImm   <= 1'b0;
      r_immIs8bit <= 1'b0;
      r_dispLen   <= 2'd0;
      r_opBytes   <= 3'd0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_needImm   <= need_imm;
        r_immIs8bit <= imm_is_8bit;
        r_dispLen   <= 2'd0;
        r_opBytes   <= {2'b00, fifo_rd_en};
      end else begin
        if (w_active && w_modrmDone) begin
          r_dispLen <= w_dispLenIn;
        end
        if (fifo_rd_en && (r_opBytes < 3'd5)) begin
          r_opBytes <= r_opBytes + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Randomized bench: the bench plays the three readers and predicts every output
// from a per-sequence phase timeline built from the decoded flags.
module tb_operand_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, has_modrm, need_imm, imm_is_8bit, flush;
  logic       busy, complete;
  logic [2:0] operand_bytes;
  logic       modrm_start, modrm_complete, modrm_rd_en;
  logic [1:0] modrm_disp_bytes;
  logic       disp_start, disp_is_8bit, disp_complete, disp_rd_en;
  logic       imm_start, imm_is_8bit_out, imm_complete, imm_rd_en;
  logic       fifo_rd_en;

  int total = 0;
  int bad   = 0;
  int expOb = 0;

  always #5 clk = ~clk;

  operand_fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .has_modrm(has_modrm),
    .need_imm(need_imm), .imm_is_8bit(imm_is_8bit), .flush(flush),
    .busy(busy), .complete(complete), .operand_bytes(operand_bytes),
    .modrm_start(modrm_start), .modrm_complete(modrm_complete),
    .modrm_disp_bytes(modrm_disp_bytes), .modrm_rd_en(modrm_rd_en),
    .disp_start(disp_start), .disp_is_8bit(disp_is_8bit),
    .disp_complete(disp_complete), .disp_rd_en(disp_rd_en),
    .imm_start(imm_start), .imm_is_8bit_out(imm_is_8bit_out),
    .imm_complete(imm_complete), .imm_rd_en(imm_rd_en),
    .fifo_rd_en(fifo_rd_en)
  );

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkQuiet(input string where, input int ob);
    checkOutput({where, " busy"}, busy, 0);
    checkOutput({where, " complete"}, complete, 0);
    checkOutput({where, " modrm_start"}, modrm_start, 0);
    checkOutput({where, " disp_start"}, disp_start, 0);
    checkOutput({where, " imm_start"}, imm_start, 0);
    checkOutput({where, " fifo_rd_en"}, fifo_rd_en, 0);
    checkOutput({where, " operand_bytes"}, operand_bytes, ob);
  endtask

  // Idle cycles: readers chatter randomly, nothing may leak through.
  task automatic checkIdle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      flush = 1'($urandom_range(0, 1));
      has_modrm = 1'($urandom_range(0, 1));
      need_imm = 1'($urandom_range(0, 1));
      imm_is_8bit = 1'($urandom_range(0, 1));
      modrm_rd_en = 1'($urandom_range(0, 1));
      disp_rd_en = 1'($urandom_range(0, 1));
      imm_rd_en = 1'($urandom_range(0, 1));
      modrm_complete = 1'($urandom_range(0, 1));
      disp_complete = 1'($urandom_range(0, 1));
      imm_complete = 1'($urandom_range(0, 1));
      modrm_disp_bytes = 2'($urandom_range(0, 3));
      #3;
      checkQuiet("idle", expOb);
      @(posedge clk); #1;
    end
  endtask

  // One instruction's operand fetch. Phases are (reader, bytes); phase p starts at
  // cycle phStart[p] and its reader completes at phStart[p+1], where the next starts.
  task automatic applyStimulus(input bit hm, input bit ni, input bit i8, input logic [1:0] db,
                               input int flushPh, input int resetPh);
    int phReader[3], phBytes[3], phLen[3], phStart[4], remaining[3];
    int nPh, dl, lastT, popped, cp, flushAt, resetAt;
    bit pop;
    bit inSeq[3], rdv[3], cmpv[3], expSt[3];
    nPh = 0; popped = 0; flushAt = -1; resetAt = -1;
    for (int r = 0; r < 3; r++) begin
      phReader[r] = 0; phBytes[r] = 0; phLen[r] = 0; remaining[r] = 0; inSeq[r] = 0;
    end
    dl = (db == 2'd3) ? 2 : int'(db);
    if (hm) begin
      phReader[nPh] = 0; phBytes[nPh] = 1; nPh++;
      if (dl != 0) begin phReader[nPh] = 1; phBytes[nPh] = dl; nPh++; end
    end
    if (ni) begin phReader[nPh] = 2; phBytes[nPh] = i8 ? 1 : 2; nPh++; end
    phStart[0] = 0;
    for (int p = 0; p < nPh; p++) begin
      phLen[p] = phBytes[p] + $urandom_range(0, 2);
      remaining[p] = phBytes[p];
      phStart[p+1] = phStart[p] + phLen[p];
      inSeq[phReader[p]] = 1;
    end
    lastT = phStart[nPh];
    if (flushPh >= 0 && flushPh < nPh) flushAt = phStart[flushPh] + $urandom_range(1, phLen[flushPh]);
    if (resetPh >= 0 && resetPh < nPh) resetAt = phStart[resetPh] + $urandom_range(1, phLen[resetPh]);

    for (int t = 0; t <= lastT; t++) begin
      cp = -1;
      for (int p = 0; p < nPh; p++) if (phStart[p] <= t) cp = p;
      start       = (t == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      has_modrm   = (t == 0) ? hm : 1'($urandom_range(0, 1));
      need_imm    = (t == 0) ? ni : 1'($urandom_range(0, 1));
      imm_is_8bit = (t == 0) ? i8 : 1'($urandom_range(0, 1));
      flush       = (t == flushAt);
      for (int r = 0; r < 3; r++) begin
        rdv[r]  = 1'($urandom_range(0, 1));
        cmpv[r] = !inSeq[r] && ($urandom_range(0, 3) == 0);
        expSt[r] = 0;
      end
      for (int p = 0; p < nPh; p++) begin
        if (phStart[p] + phLen[p] == t) cmpv[phReader[p]] = 1;
        if (phStart[p] == t && t != flushAt) expSt[phReader[p]] = 1;
      end
      pop = 0;
      if (cp >= 0) begin
        pop = (remaining[cp] > 0) && (t < phStart[cp] + phLen[cp]) &&
              ((remaining[cp] == phStart[cp] + phLen[cp] - t) || ($urandom_range(0, 1) == 1));
        rdv[phReader[cp]] = pop;
      end
      modrm_disp_bytes = (hm && t == phLen[0]) ? db : 2'($urandom_range(0, 3));
      modrm_rd_en = rdv[0]; disp_rd_en = rdv[1]; imm_rd_en = rdv[2];
      modrm_complete = cmpv[0]; disp_complete = cmpv[1]; imm_complete = cmpv[2];
      #3;
      if (t == resetAt) begin
        reset = 1'b1;
        #1;
        checkQuiet("in reset", 0);
        @(posedge clk); #1;
        reset = 1'b0;
        expOb = 0;
        break;
      end
      checkOutput("modrm_start", modrm_start, expSt[0]);
      checkOutput("disp_start", disp_start, expSt[1]);
      checkOutput("imm_start", imm_start, expSt[2]);
      checkOutput("complete", complete, (t == lastT) && (t != flushAt));
      checkOutput("busy", busy, (t != lastT) || (t == flushAt));
      checkOutput("fifo_rd_en", fifo_rd_en, pop && (t != flushAt));
      checkOutput("operand_bytes", operand_bytes, (t == 0) ? expOb : popped);
      if (expSt[1]) checkOutput("disp_is_8bit", disp_is_8bit, dl == 1);
      if (expSt[2]) checkOutput("imm_is_8bit_out", imm_is_8bit_out, i8);
      if (pop && t != flushAt) begin popped++; remaining[cp]--; end
      @(posedge clk); #1;
      if (t == flushAt) break;
    end
    if (resetAt < 0) expOb = popped;
    flush = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1; has_modrm = 1'b1; need_imm = 1'b1; imm_is_8bit = 1'b0; flush = 1'b0;
    modrm_complete = 1'b1; disp_complete = 1'b1; imm_complete = 1'b1;
    modrm_rd_en = 1'b1; disp_rd_en = 1'b1; imm_rd_en = 1'b1; modrm_disp_bytes = 2'd2;
    #3;
    checkQuiet("power-up reset", 0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkIdle(2);

    applyStimulus(1, 1, 0, 2'd2, -1, -1);
    checkIdle(1);
    applyStimulus(0, 0, 0, 2'd0, -1, -1);
    checkIdle(1);
    applyStimulus(1, 0, 0, 2'd0, -1, -1);
    checkIdle(1);
    applyStimulus(1, 0, 1, 2'd1, 1, -1);
    checkIdle(1);
    applyStimulus(1, 1, 1, 2'd3, -1, -1);
    checkIdle(1);
    applyStimulus(1, 1, 0, 2'd2, -1, 2);
    checkIdle(1);
    applyStimulus(0, 1, 1, 2'd1, -1, -1);
    checkIdle(1);

    for (int n = 0; n < 80; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1);
      checkIdle($urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
